// File: rtl/pc_sequencer.sv
// Program-counter stage for the single-cycle core: next-PC selection, fetch address/strobe,
// and a boot/run/halt/fault sequencer that stops fetching on halt or an illegal address.
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'd400,
  parameter logic [31:0] MEM_TOP    = 32'd508,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  input  logic [5:0]  opCode,
  output logic [31:0] curPC,
  output logic [31:0] nextPC,
  output logic        InsMemRW,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc4, br_target, jmp_target;
  logic        fetch_bad;

  always_comb begin
    pc4        = pc_q + 32'd4;
    br_target  = pc4 + {{14{imm[15]}}, imm, 2'b00};
    jmp_target = {pc4[31:28], jaddr, 2'b00};
    unique case (PCSrc)
      2'b01:   nextPC = br_target;
      2'b10:   nextPC = jmp_target;
      default: nextPC = pc4;
    endcase
  end

  assign fetch_bad = (nextPC[1:0] != 2'b00) || (nextPC > MEM_TOP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        // A stalled cycle defers the halt check as well as the PC update.
        if (PCWre) begin
          if (opCode == HALT_OP) begin
            state_d = StHalt;
          end else if (fetch_bad) begin
            state_d = StFault;
          end else begin
            pc_d  = nextPC;
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_ADDR;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign curPC       = pc_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == StHalt);
  assign fault       = (state_q == StFault);
  assign InsMemRW    = (state_q == StHalt) || (state_q == StFault);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed steps followed by random traffic, all compared against
// a behavioural model of the fetch sequencer held in plain variables.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [15:0] imm = 16'd0;
  logic [25:0] jaddr = 26'd0;
  logic [5:0]  opCode = 6'd0;
  logic [31:0] curPC, nextPC, instr_count;
  logic        InsMemRW, halted, fault;

  int checks = 0;
  int errors = 0;

  // Model: 0 boot, 1 run, 2 halt, 3 fault
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .imm(imm), .jaddr(jaddr),
    .opCode(opCode), .curPC(curPC), .nextPC(nextPC), .InsMemRW(InsMemRW), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [15:0] im, input logic [25:0] ja);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (src == 2'b01) return p4 + 32'(int'($signed(im)) * 4);
    if (src == 2'b10) return (p4 & 32'hF000_0000) | (32'(ja) * 32'd4);
    return p4;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".curPC"}, curPC, m_pc);
    check({tag, ".count"}, instr_count, m_cnt);
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode == 2});
    check({tag, ".fault"}, {31'd0, fault}, {31'd0, m_mode == 3});
    check({tag, ".InsMemRW"}, {31'd0, InsMemRW}, {31'd0, m_mode >= 2});
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    #1;
    Reset = 1'b1;
    #1;
    m_mode = 0;
    m_pc   = 32'd400;
    m_cnt  = 32'd0;
    check_outputs({tag, ".rst"});
    #1;
    Reset = 1'b0;
  endtask

  task automatic cycle(input string tag, input logic we, input logic [1:0] src,
                       input logic [15:0] im, input logic [25:0] ja, input logic [5:0] op);
    logic [31:0] n;
    PCWre  = we;
    PCSrc  = src;
    imm    = im;
    jaddr  = ja;
    opCode = op;
    #1;
    n = model_next(m_pc, src, im, ja);
    check({tag, ".nextPC"}, nextPC, n);
    @(posedge CLK);
    #1;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && we) begin
      if (op == 6'b111111) m_mode = 2;
      else if (n % 4 != 0 || n > 32'd508) m_mode = 3;
      else begin
        m_pc  = n;
        m_cnt = m_cnt + 1;
      end
    end
    check_outputs(tag);
  endtask

  initial begin
    @(posedge CLK);
    #1;
    // Sequential fetch through boot
    do_reset("seq");
    cycle("boot", 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("seq", 1, 2'b00, 0, 0, 0);
    check("seq.pc412", curPC, 32'd412);
    for (int i = 0; i < 3; i++) cycle("seq11", 1, 2'b11, 0, 0, 0);
    // Forward then backward branch
    cycle("br_fwd", 1, 2'b01, 16'd3, 0, 0);
    check("br_fwd.pc440", curPC, 32'd440);
    cycle("br_back", 1, 2'b01, 16'hFFFA, 0, 0);
    check("br_back.pc420", curPC, 32'd420);
    for (int i = 0; i < 6; i++) cycle("to444", 1, 2'b00, 0, 0, 0);
    // Stall defers even the halt opcode
    for (int i = 0; i < 4; i++) cycle("stall", 0, 2'b01, 16'd5, 0, 6'b111111);
    check("stall.next", nextPC, curPC + 32'd24);
    cycle("halt", 1, 2'b00, 0, 0, 6'b111111);
    check("halt.pc444", curPC, 32'd444);
    for (int i = 0; i < 3; i++)
      cycle("halt_sticky", 1, 2'($urandom), 16'($urandom), 26'($urandom), 6'($urandom));

    // Jump out of range faults; jump to the top word is legal, the word after is not
    do_reset("jmp");
    cycle("boot", 1, 2'b00, 0, 0, 0);
    cycle("jmp_bad", 1, 2'b10, 0, 26'd200, 0);
    check("jmp_bad.fault", {31'd0, fault}, 32'd1);
    for (int i = 0; i < 3; i++)
      cycle("fault_sticky", 1, 2'($urandom), 16'($urandom), 26'($urandom), 6'($urandom));
    do_reset("top");
    cycle("boot", 1, 2'b00, 0, 0, 0);
    cycle("jmp_top", 1, 2'b10, 0, 26'd127, 0);
    check("jmp_top.pc508", curPC, 32'd508);
    cycle("past_top", 1, 2'b00, 0, 0, 0);
    // Halt wins over a simultaneous bad fetch
    do_reset("prio");
    cycle("boot", 1, 2'b00, 0, 0, 0);
    cycle("prio", 1, 2'b10, 0, 26'd200, 6'b111111);

    // Reset mid-cycle from HALT with seven retired instructions
    do_reset("rh");
    cycle("boot", 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle("rh_seq", 1, 2'b00, 0, 0, 0);
    cycle("rh_halt", 1, 2'b00, 0, 0, 6'b111111);
    check("rh.count7", instr_count, 32'd7);
    do_reset("rh2");
    cycle("rh_boot", 1, 2'b00, 0, 0, 0);
    cycle("rh_adv", 1, 2'b00, 0, 0, 0);

    // Random traffic, re-reset whenever the sequencer has stopped
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      int v;
      logic [15:0] im;
      logic [25:0] ja;
      logic [5:0]  op;
      if (m_mode >= 2 && $urandom_range(0, 3) == 0) do_reset("rnd");
      v  = int'($urandom_range(0, 16)) - 8;
      im = v[15:0];
      ja = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($urandom_range(95, 130));
      op = ($urandom_range(0, 30) == 0) ? 6'b111111 : 6'($urandom_range(0, 62));
      cycle("rnd", $urandom_range(0, 4) != 0, 2'($urandom), im, ja, op);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage that sits directly upstream of the instruction memory.
- Holds the current PC and computes the next PC from the sequential, branch or jump path.
- Drives the instruction-memory address and read strobe.
- Runs a small run/halt/fault state machine, so the single-cycle core stops cleanly on the halt opcode or on an illegal fetch address.

Parameters:
- RESET_ADDR, 400, byte address loaded into the PC on reset (first instruction).
- MEM_TOP, 508, highest legal word-aligned fetch address (memory holds 512 entries, indexed by byte address).
- HALT_OP, 6'b111111, opcode value that stops the sequencer.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- PCWre  input  1  PC write enable from control unit; 0 = hold PC this cycle.
- PCSrc  input  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump, 11 = PC+4.
- imm  input  16  branch offset in words (signed), from the instruction decode fields.
- jaddr  input  26  jump target field, instruction bits [25:0].
- opCode  input  6  opcode of the instruction currently fetched.
- curPC  output  32  current PC; feeds instruction-memory iAddr.
- nextPC  output  32  combinational next-PC value (observability/debug).
- InsMemRW  output  1  instruction-memory read strobe; 0 = read.
- halted  output  1  high in HALT state.
- fault  output  1  high in FAULT state.
- instr_count  output  32  count of retired (PC-advancing) instructions.

Behaviour:
- States: BOOT, RUN, HALT, FAULT. Encoding is free.
- Reset (async, any time, including mid-instruction):
  - state = BOOT, curPC = RESET_ADDR, instr_count = 0, halted = 0, fault = 0, InsMemRW = 0.
- Next-PC arithmetic, combinational, 32-bit, wraps modulo 2^32:
  - pc4 = curPC + 4.
  - Branch target = pc4 + (sign_extend(imm) << 2).
  - Jump target = {pc4[31:28], jaddr, 2'b00}.
  - nextPC reflects the PCSrc selection at all times, in every state.
- BOOT: lasts exactly one cycle; PC is not updated; goes to RUN. This gives the instruction memory one full cycle to present the first instruction.
- RUN, on each rising edge, in priority order:
  1. PCWre = 0: hold curPC and instr_count; stay in RUN. The halt check is also deferred.
  2. opCode == HALT_OP: go to HALT; curPC unchanged; instr_count unchanged.
  3. nextPC[1:0] != 0 or nextPC > MEM_TOP: go to FAULT; curPC unchanged.
  4. Otherwise: curPC <= nextPC; instr_count <= instr_count + 1 (wraps at 2^32); stay in RUN.
- HALT and FAULT are sticky until Reset:
  - curPC and instr_count frozen; all inputs ignored.
  - halted = 1 in HALT only; fault = 1 in FAULT only.
  - HALT has priority over FAULT when both conditions hold in the same cycle.
- InsMemRW: 0 in BOOT and RUN; 1 in HALT and FAULT, which blocks further memory reads.
- Latency: curPC changes one edge after the PCSrc/imm selection is presented; no other pipelining.
- PCSrc = 11 is treated as sequential; it is not an error.

Test Plan:
- Reset, then 1 clock, then 3 clocks with PCWre = 1 and PCSrc = 00, opCode = 0 → curPC 400 through BOOT, then 404, 408, 412; instr_count = 3; InsMemRW = 0.
- From curPC = 424: PCSrc = 01, imm = 3 → curPC = 440. From 440: PCSrc = 01, imm = 16'hFFFA → curPC = 420. instr_count increments by 1 on each.
- From curPC = 444: opCode = 6'b111111, PCWre = 1 → halted = 1, curPC stays 444, InsMemRW = 1. Further edges with any inputs → no change.
- From curPC = 400: PCSrc = 10, jaddr = 26'd200 → nextPC = 800 > MEM_TOP → fault = 1, curPC stays 400. Separately, branch imm making nextPC = 402 is impossible (always aligned); jump to 26'd127 → 508 is legal, curPC = 508.
- PCWre = 0 for 4 cycles in RUN with PCSrc = 01, imm = 5 → curPC and instr_count unchanged; nextPC = curPC + 24 throughout.
- Assert Reset asynchronously between edges while in HALT with instr_count = 7 → immediately curPC = 400, halted = 0, instr_count = 0; next edge stays in BOOT behaviour (no PC advance), following edge advances.
